rv32i_alu_regfile: RTL and testbench
====================================

// Module: rv32i_alu_regfile
// PURPOSE
//  RV32I execute datapath: 32x32 register file plus integer ALU, operand-B mux and write-back mux.
//  Sits under the single-cycle CPU control logic, which supplies decoded fields and control strobes.
//  Reads and the ALU are combinational; register write-back is synchronous.
// PARAMETERS
//  XLEN   32  data width of registers, ALU and immediates
//  NREGS  32  register count; address width = $clog2(NREGS) = 5
// PORTS
//  clk         in   1     single clock; write-back on rising edge
//  reset       in   1     asynchronous, active-high; clears all registers
//  rs1_addr    in   5     read port 1 address
//  rs2_addr    in   5     read port 2 address
//  rd_addr     in   5     write address
//  write_en    in   1     register write strobe
//  imm         in   XLEN  sign-extended immediate (I- or U-form, from decoder)
//  b_sel       in   1     0: ALU B = rs2_data, 1: ALU B = imm
//  alu_op      in   3     funct3 operation select
//  funct7      in   7     funct7 field; bit 5 is the alternate-op select
//  is_imm      in   1     1 for OP-IMM: suppresses SUB on alu_op 000
//  link_addr   in   XLEN  PC+4 from fetch, used for JAL/JALR link
//  wb_sel      in   2     00 ALU result, 01 imm (LUI), 10 link_addr, 11 zero
//  rs1_data    out  XLEN  register[rs1_addr]
//  rs2_data    out  XLEN  register[rs2_addr]
//  alu_result  out  XLEN  ALU output
//  wb_data     out  XLEN  selected write-back value
// BEHAVIOUR
//  - Reset: all registers are 0 asynchronously, immediately on assertion. The read outputs then show 0.
//    alu_result and wb_data follow combinationally from the cleared values.
//  - Reads: combinational, zero latency. Address 0 always reads 0.
//  - Write: at posedge clk when write_en=1 and reset=0, reg[rd_addr] <= wb_data.
//    Writes to x0 are discarded.
//  - Read-during-write to the same address returns the OLD value until the edge. There is no bypass.
//  - Reset asserted during a write edge: reset wins and nothing is written.
//  - ALU, A = rs1_data, B = b_sel ? imm : rs2_data. All ops wrap modulo 2^32 with no flags.
//      000  ADD; SUB when funct7[5]=1 and is_imm=0
//      001  SLL by B[4:0]
//      010  SLT signed, result 0 or 1
//      011  SLTU unsigned, result 0 or 1
//      100  XOR
//      101  SRL; SRA when funct7[5]=1 (valid for SRAI too)
//      110  OR
//      111  AND
//    Shift amounts ignore B[31:5].
//  - wb_data mux is combinational. wb_sel=11 yields 0.
//  - Pure function of the current register contents and inputs. No other state, no handshake.
// STRUCTURE
//  - Shared package rv32i_pkg holds:
//      XLEN and register-address width
//      ALU funct3 localparams: ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SR, ALU_OR, ALU_AND
//      WB_ALU / WB_IMM / WB_LINK / WB_ZERO encodings
//  - One natural sub-module: rv32i_alu (combinational: A, B, op, alt, is_imm -> out).
//  - Register array, operand mux and write-back mux stay inline.
// TESTING
//  - Reset then read all 32 addresses -> every rs1_data/rs2_data read is 0.
//  - imm=5, b_sel=1, op=000, is_imm=1, rd=1, we=1, one edge -> x1=5.
//    Then imm=-3 with funct7=7'h7F (upper imm bits) -> alu_result=2, not a subtraction.
//  - Preload x1=5 and x2=7; b_sel=0, op=000, funct7=0x20, is_imm=0 -> alu_result=0xFFFFFFFE.
//    SLT -> 1; SLTU with x1=-1 -> 0.
//  - x1=0x80000000, op=101, imm shamt 4: funct7[5]=1 -> 0xF8000000; funct7[5]=0 -> 0x08000000.
//  - Write 0xDEAD to rd=0 -> x0 still reads 0.
//    wb_sel=01, imm=0x12345000, rd=3 -> x3=0x12345000.
//    wb_sel=10, link_addr=0x104 -> rd gets 0x104.
//  - Assert reset between clock edges after writes -> registers clear without waiting for an edge.
//    A same-cycle read of the write target shows the old value before the edge and the new value after.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I execute datapath: widths, ALU funct3 codes, write-back selects.
package rv32i_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = $clog2(NREGS);

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_funct_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_IMM  = 2'b01,
    WB_LINK = 2'b10,
    WB_ZERO = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/rv32i_alu.sv
// Combinational RV32I integer ALU selected by funct3, with funct7[5] alternate-op select.
module rv32i_alu
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = rv32i_pkg::XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  input  logic            alt,
  input  logic            is_imm,
  output logic [XLEN-1:0] out
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    out = '0;
    case (alu_funct_e'(op))
      // OP-IMM reuses funct7 bits as immediate, so alt must not select SUB there
      ALU_ADD:  out = (alt && !is_imm) ? a - b : a + b;
      ALU_SLL:  out = a << shamt;
      ALU_SLT:  out = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: out = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  out = a ^ b;
      ALU_SR:   out = alt ? XLEN'($signed(a) >>> shamt) : a >> shamt;
      ALU_OR:   out = a | b;
      ALU_AND:  out = a & b;
      default:  out = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_alu_regfile.sv
// RV32I execute datapath: register file with combinational reads, ALU, operand-B and write-back muxes.
module rv32i_alu_regfile #(
  parameter int unsigned XLEN  = rv32i_pkg::XLEN,
  parameter int unsigned NREGS = rv32i_pkg::NREGS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  input  logic                     write_en,
  input  logic [XLEN-1:0]          imm,
  input  logic                     b_sel,
  input  logic [2:0]               alu_op,
  input  logic [6:0]               funct7,
  input  logic                     is_imm,
  input  logic [XLEN-1:0]          link_addr,
  input  logic [1:0]               wb_sel,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  output logic [XLEN-1:0]          alu_result,
  output logic [XLEN-1:0]          wb_data
);

  import rv32i_pkg::*;

  logic [XLEN-1:0] regs [1:NREGS-1];
  logic [XLEN-1:0] alu_b;
  logic            unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // x0 has no storage; its reads are forced to zero
  assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
  assign alu_b    = b_sel ? imm : rs2_data;

  rv32i_alu #(.XLEN(XLEN)) u_alu (
    .a      (rs1_data),
    .b      (alu_b),
    .op     (alu_op),
    .alt    (funct7[5]),
    .is_imm (is_imm),
    .out    (alu_result)
  );

  always_comb begin
    wb_data = '0;
    case (wb_sel_e'(wb_sel))
      WB_ALU:  wb_data = alu_result;
      WB_IMM:  wb_data = imm;
      WB_LINK: wb_data = link_addr;
      WB_ZERO: wb_data = '0;
      default: wb_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (write_en && rd_addr != '0) begin
      regs[rd_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_rv32i_alu_regfile.sv
// Directed bench for rv32i_alu_regfile: expectations queued at drive time, popped at sample time.
module tb_rv32i_alu_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        write_en;
  logic [31:0] imm;
  logic        b_sel;
  logic [2:0]  alu_op;
  logic [6:0]  funct7;
  logic        is_imm;
  logic [31:0] link_addr;
  logic [1:0]  wb_sel;
  logic [31:0] rs1_data, rs2_data, alu_result, wb_data;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  rv32i_alu_regfile #(.XLEN(32), .NREGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .write_en   (write_en),
    .imm        (imm),
    .b_sel      (b_sel),
    .alu_op     (alu_op),
    .funct7     (funct7),
    .is_imm     (is_imm),
    .link_addr  (link_addr),
    .wb_sel     (wb_sel),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .alu_result (alu_result),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_item_t it;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty: observed %h with no expectation queued", obs);
      return;
    end
    it = sb.pop_front();
    assert (obs === it.exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
    end
  endtask

  // Load a register through the LUI path (wb_sel=01), leaving write_en low afterwards.
  task automatic load_reg(input logic [4:0] rd, input logic [31:0] val);
    @(negedge clk);
    rd_addr  = rd;
    imm      = val;
    wb_sel   = 2'b01;
    write_en = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic alu_rr(input logic [2:0] op, input logic [6:0] f7, input string tag, input logic [31:0] exp);
    @(negedge clk);
    b_sel = 1'b0; is_imm = 1'b0; alu_op = op; funct7 = f7;
    push(tag, exp);
    #1 chk(alu_result);
  endtask

  task automatic alu_ri(input logic [2:0] op, input logic [6:0] f7, input logic [31:0] iv, input string tag,
                        input logic [31:0] exp);
    @(negedge clk);
    b_sel = 1'b1; is_imm = 1'b1; alu_op = op; funct7 = f7; imm = iv;
    push(tag, exp);
    #1 chk(alu_result);
  endtask

  initial begin
    reset = 1'b1; rs1_addr = '0; rs2_addr = '0; rd_addr = '0; write_en = 1'b0;
    imm = '0; b_sel = 1'b0; alu_op = '0; funct7 = '0; is_imm = 1'b0; link_addr = '0; wb_sel = '0;

    // Reset: every address reads zero on both ports
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      push("reset_rs1", 32'h0);
      push("reset_rs2", 32'h0);
      #1;
      chk(rs1_data);
      chk(rs2_data);
    end

    // ADDI x1 = x0 + 5, watching x1 on rs2 across the write edge
    @(negedge clk);
    rs1_addr = 5'd0; rs2_addr = 5'd1; rd_addr = 5'd1;
    imm = 32'd5; b_sel = 1'b1; alu_op = 3'b000; is_imm = 1'b1; funct7 = 7'h00;
    wb_sel = 2'b00; write_en = 1'b1;
    push("addi_result", 32'd5);
    push("rdw_old", 32'd0);
    #1;
    chk(alu_result);
    chk(rs2_data);
    @(posedge clk);
    #1;
    write_en = 1'b0;
    push("rdw_new", 32'd5);
    chk(rs2_data);

    // ADDI with negative imm and funct7 bits set: still an add
    rs1_addr = 5'd1;
    alu_ri(3'b000, 7'h7F, 32'hFFFF_FFFD, "addi_neg_no_sub", 32'd2);

    // Register-register ops with x1=5, x2=7
    load_reg(5'd2, 32'd7);
    @(negedge clk);
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    alu_rr(3'b000, 7'h20, "sub", 32'hFFFF_FFFE);
    alu_rr(3'b000, 7'h00, "add", 32'd12);
    alu_rr(3'b010, 7'h00, "slt_5_7", 32'd1);
    alu_rr(3'b001, 7'h00, "sll_reg", 32'h0000_0280);
    alu_rr(3'b100, 7'h00, "xor", 32'd2);
    alu_rr(3'b110, 7'h00, "or", 32'd7);
    alu_rr(3'b111, 7'h00, "and", 32'd5);
    alu_ri(3'b001, 7'h00, 32'h0000_0021, "slli_shamt_mask", 32'd10);

    // x1 = -1: signed vs unsigned compare
    load_reg(5'd1, 32'hFFFF_FFFF);
    alu_rr(3'b010, 7'h00, "slt_neg", 32'd1);
    alu_rr(3'b011, 7'h00, "sltu_neg", 32'd0);

    // Shifts right on x1 = 0x80000000
    load_reg(5'd1, 32'h8000_0000);
    alu_ri(3'b101, 7'h20, 32'd4, "srai", 32'hF800_0000);
    alu_ri(3'b101, 7'h00, 32'd4, "srli", 32'h0800_0000);
    alu_ri(3'b101, 7'h20, 32'h0000_0404, "srai_imm_bits", 32'hF800_0000);

    // Write to x0 is discarded
    load_reg(5'd0, 32'h0000_DEAD);
    @(negedge clk);
    rs1_addr = 5'd0;
    push("x0_write", 32'd0);
    #1 chk(rs1_data);

    // LUI path into x3
    @(negedge clk);
    rd_addr = 5'd3; imm = 32'h1234_5000; wb_sel = 2'b01; write_en = 1'b1;
    push("wb_imm", 32'h1234_5000);
    #1 chk(wb_data);
    @(posedge clk);
    #1;
    write_en = 1'b0;
    rs1_addr = 5'd3;
    push("lui_x3", 32'h1234_5000);
    #1 chk(rs1_data);

    // Link path into x4, then wb_sel=11 gives zero
    @(negedge clk);
    rd_addr = 5'd4; link_addr = 32'h0000_0104; wb_sel = 2'b10; write_en = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    rs2_addr = 5'd4;
    wb_sel   = 2'b11;
    push("link_x4", 32'h0000_0104);
    push("wb_zero", 32'h0);
    #1;
    chk(rs2_data);
    chk(wb_data);

    // Asynchronous reset between edges clears immediately
    @(negedge clk);
    #2 reset = 1'b1;
    push("async_rst_x3", 32'h0);
    push("async_rst_x4", 32'h0);
    #1;
    chk(rs1_data);
    chk(rs2_data);
    @(negedge clk);
    reset = 1'b0;

    // Reset held across a write edge: nothing lands
    load_reg(5'd5, 32'h0000_00AA);
    @(negedge clk);
    rd_addr = 5'd6; imm = 32'h0000_00BB; wb_sel = 2'b01; write_en = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    reset    = 1'b0;
    rs1_addr = 5'd6;
    rs2_addr = 5'd5;
    push("rst_wins_x6", 32'h0);
    push("rst_clears_x5", 32'h0);
    #1;
    chk(rs1_data);
    chk(rs2_data);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
